// File: rtl/dcache_store_coalescer.sv
// dcache_store_coalescer
// Write-combining store buffer in front of the dcache data store SRAM.
// Word stores are collected into line-wide entries with byte masks and
// drained one entry per cycle as masked line writes. Loads take priority on
// the shared SRAM port unless they hit a line that is still buffered.
// Optional feature: define DCACHE_SC_MERGE_EN to let a store combine into
// the youngest entry when it targets the same line.
module dcache_store_coalescer #(
  parameter  int DATA_WIDTH = 128,
  parameter  int NUM_WORDS  = 256,
  parameter  int WORD_WIDTH = 64,
  parameter  int DEPTH      = 4,
  localparam int AW         = $clog2(NUM_WORDS),
  localparam int WPL        = DATA_WIDTH / WORD_WIDTH,
  localparam int OW         = $clog2(WPL)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    st_valid_i,
  output logic                    st_ready_o,
  input  logic [AW-1:0]           st_index_i,
  input  logic [OW-1:0]           st_offset_i,
  input  logic [WORD_WIDTH-1:0]   st_wdata_i,
  input  logic [WORD_WIDTH/8-1:0] st_be_i,
  input  logic                    ld_req_i,
  input  logic [AW-1:0]           ld_index_i,
  output logic                    ld_gnt_o,
  input  logic                    flush_i,
  output logic                    empty_o,
  output logic                    ds_en_o,
  output logic                    ds_we_o,
  output logic [AW-1:0]           ds_addr_o,
  output logic [DATA_WIDTH-1:0]   ds_wdata_o,
  output logic [DATA_WIDTH/8-1:0] ds_byte_o
);

  localparam int BPW = WORD_WIDTH / 8;
  localparam int BPL = DATA_WIDTH / 8;
  localparam int PW  = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DEPTH-1:0]      ent_valid;
  logic [AW-1:0]         ent_index [DEPTH];
  logic [DATA_WIDTH-1:0] ent_line  [DEPTH];
  logic [BPL-1:0]        ent_mask  [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic full;
  logic empty;
  logic conflict;
  logic grant;
  logic drain;
  logic merge_hit;
  logic accept;
  logic alloc;

  logic [DATA_WIDTH-1:0] placed_line;
  logic [BPL-1:0]        placed_mask;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign empty_o = empty;

  // Spread the incoming word into its slot in a line-wide image; only
  // enabled bytes show up in the data and the mask.
  always_comb begin
    placed_line = '0;
    placed_mask = '0;
    for (int w = 0; w < WPL; w++) begin
      for (int b = 0; b < BPW; b++) begin
        if ((st_offset_i == OW'(w)) && st_be_i[b]) begin
          placed_mask[w*BPW+b]          = 1'b1;
          placed_line[(w*BPW+b)*8 +: 8] = st_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // A load must wait while any buffered entry still owns its line.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_index[i] == ld_index_i)) begin
        conflict = 1'b1;
      end
    end
  end

  // Loads win the port; drains only use cycles no clean load wants.
  assign grant = ld_req_i & ~conflict & ~rst_i;
  assign drain = ~grant & ~empty;

`ifdef DCACHE_SC_MERGE_EN
  logic [PW-1:0] young;
  assign young     = tail - PW'(1);
  assign merge_hit = st_valid_i & ent_valid[young] &
                     (ent_index[young] == st_index_i) &
                     ~(drain & (young == head));
`else
  assign merge_hit = 1'b0;
`endif

  // Ready looks at the pre-drain count so a full buffer never takes a new
  // entry on the strength of a same-cycle drain.
  assign st_ready_o = ~flush_i & (~full | merge_hit);
  assign accept     = st_valid_i & st_ready_o;
  assign alloc      = accept & ~merge_hit;

  // Drive the data store port: load read, head drain, or idle.
  always_comb begin
    ld_gnt_o   = 1'b0;
    ds_en_o    = 1'b0;
    ds_we_o    = 1'b0;
    ds_addr_o  = '0;
    ds_wdata_o = '0;
    ds_byte_o  = '0;
    if (grant) begin
      ld_gnt_o  = 1'b1;
      ds_en_o   = 1'b1;
      ds_addr_o = ld_index_i;
    end else if (drain) begin
      ds_en_o    = 1'b1;
      ds_we_o    = 1'b1;
      ds_addr_o  = ent_index[head];
      ds_wdata_o = ent_line[head];
      ds_byte_o  = ent_mask[head];
    end
  end

  // Occupancy bookkeeping; reset throws away anything still pending.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent_valid <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (drain) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      if (alloc) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PW'(1);
      end
      count <= count + (PW+1)'(alloc) - (PW+1)'(drain);
    end
  end

  // Entry payload; gated by valid, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      ent_index[tail] <= st_index_i;
      ent_line[tail]  <= placed_line;
      ent_mask[tail]  <= placed_mask;
    end
`ifdef DCACHE_SC_MERGE_EN
    else if (accept && merge_hit) begin
      for (int k = 0; k < BPL; k++) begin
        if (placed_mask[k]) begin
          ent_line[young][k*8 +: 8] <= placed_line[k*8 +: 8];
        end
      end
      ent_mask[young] <= ent_mask[young] | placed_mask;
    end
`endif
  end

endmodule

// File: tb/tb_dcache_store_coalescer.sv
// Directed self-checking bench for dcache_store_coalescer (default params).
// Expectations follow DCACHE_SC_MERGE_EN when it is defined for the build.
module tb_dcache_store_coalescer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         st_valid_i;
  logic         st_ready_o;
  logic [7:0]   st_index_i;
  logic [0:0]   st_offset_i;
  logic [63:0]  st_wdata_i;
  logic [7:0]   st_be_i;
  logic         ld_req_i;
  logic [7:0]   ld_index_i;
  logic         ld_gnt_o;
  logic         flush_i;
  logic         empty_o;
  logic         ds_en_o;
  logic         ds_we_o;
  logic [7:0]   ds_addr_o;
  logic [127:0] ds_wdata_o;
  logic [15:0]  ds_byte_o;

  int total = 0;
  int bad   = 0;

  dcache_store_coalescer dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .st_valid_i (st_valid_i),
    .st_ready_o (st_ready_o),
    .st_index_i (st_index_i),
    .st_offset_i(st_offset_i),
    .st_wdata_i (st_wdata_i),
    .st_be_i    (st_be_i),
    .ld_req_i   (ld_req_i),
    .ld_index_i (ld_index_i),
    .ld_gnt_o   (ld_gnt_o),
    .flush_i    (flush_i),
    .empty_o    (empty_o),
    .ds_en_o    (ds_en_o),
    .ds_we_o    (ds_we_o),
    .ds_addr_o  (ds_addr_o),
    .ds_wdata_o (ds_wdata_o),
    .ds_byte_o  (ds_byte_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] idx, input logic [0:0] off,
                               input logic [63:0] data, input logic [7:0] be);
    st_valid_i  = v;
    st_index_i  = idx;
    st_offset_i = off;
    st_wdata_i  = data;
    st_be_i     = be;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i    = 1'b1;
    ld_req_i = 1'b0;
    ld_index_i = 8'd0;
    flush_i  = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0, 64'd0, 8'd0);
    #3;
    checkOutput("rst_ready", st_ready_o, 1);
    checkOutput("rst_empty", empty_o, 1);
    checkOutput("rst_gnt", ld_gnt_o, 0);
    checkOutput("rst_en", ds_en_o, 0);
    tick();
    tick();
    rst_i = 1'b0;

    // single store placed in word slot 1
    tick();
    applyStimulus(1'b1, 8'd5, 1'b1, 64'hA5A5_0000_0000_1234, 8'h03);
    #1;
    checkOutput("s1_ready", st_ready_o, 1);
    checkOutput("s1_idle", ds_en_o, 0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 64'd0, 8'd0);
    #1;
    checkOutput("s1_we", ds_we_o, 1);
    checkOutput("s1_addr", ds_addr_o, 5);
    checkOutput("s1_byte", ds_byte_o, 16'h0300);
    checkOutput("s1_data16", ds_wdata_o[79:64], 16'h1234);
    checkOutput("s1_data", ds_wdata_o, 128'h0000_0000_0000_1234_0000_0000_0000_0000);
    checkOutput("s1_nempty", empty_o, 0);
    tick();
    checkOutput("s1_empty", empty_o, 1);
    checkOutput("s1_done", ds_en_o, 0);

    // two stores to line 7 while a load to line 3 holds the port
    ld_req_i = 1'b1;
    ld_index_i = 8'd3;
    applyStimulus(1'b1, 8'd7, 1'b0, 64'h1111_2222_3333_4444, 8'hFF);
    #1;
    checkOutput("m_gnt0", ld_gnt_o, 1);
    checkOutput("m_rd", ds_we_o, 0);
    checkOutput("m_rdaddr", ds_addr_o, 3);
    tick();
    applyStimulus(1'b1, 8'd7, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0);
    #1;
    checkOutput("m_gnt1", ld_gnt_o, 1);
    checkOutput("m_ready1", st_ready_o, 1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 64'd0, 8'd0);
    ld_req_i = 1'b0;
    #1;
    checkOutput("m_we0", ds_we_o, 1);
    checkOutput("m_addr0", ds_addr_o, 7);
`ifdef DCACHE_SC_MERGE_EN
    checkOutput("m_byte", ds_byte_o, 16'hF0FF);
    checkOutput("m_data", ds_wdata_o, 128'hAAAA_BBBB_0000_0000_1111_2222_3333_4444);
    tick();
    checkOutput("m_empty", empty_o, 1);
`else
    checkOutput("m_byte0", ds_byte_o, 16'h00FF);
    checkOutput("m_data0", ds_wdata_o, 128'h0000_0000_0000_0000_1111_2222_3333_4444);
    tick();
    checkOutput("m_we1", ds_we_o, 1);
    checkOutput("m_addr1", ds_addr_o, 7);
    checkOutput("m_byte1", ds_byte_o, 16'hF000);
    checkOutput("m_data1", ds_wdata_o, 128'hAAAA_BBBB_0000_0000_0000_0000_0000_0000);
    tick();
    checkOutput("m_empty", empty_o, 1);
`endif

    // fill all four entries under a load to line 9
    ld_req_i = 1'b1;
    ld_index_i = 8'd9;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(20 + i), 1'b0, 64'(i + 1), 8'h01);
      #1;
      checkOutput("f_ready", st_ready_o, 1);
      checkOutput("f_gnt", ld_gnt_o, 1);
      tick();
    end
    applyStimulus(1'b1, 8'd24, 1'b0, 64'hFF, 8'h01);
    #1;
    checkOutput("f_full", st_ready_o, 0);
    checkOutput("f_gntfull", ld_gnt_o, 1);
    tick();
    checkOutput("f_full2", st_ready_o, 0);
    ld_req_i = 1'b0;
    applyStimulus(1'b1, 8'd30, 1'b0, 64'hFF, 8'h01);
    #1;
    checkOutput("f_drainref", st_ready_o, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("f_dwe", ds_we_o, 1);
      checkOutput("f_daddr", ds_addr_o, 20 + i);
      checkOutput("f_ddata", ds_wdata_o, 128'(i + 1));
      tick();
      applyStimulus(1'b0, 8'd0, 1'b0, 64'd0, 8'd0);
      #1;
    end
    checkOutput("f_empty", empty_o, 1);

    // load blocked by a pending entry to the same line
    applyStimulus(1'b1, 8'd12, 1'b0, 64'h55, 8'h01);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 64'd0, 8'd0);
    ld_req_i = 1'b1;
    ld_index_i = 8'd12;
    #1;
    checkOutput("c_gnt0", ld_gnt_o, 0);
    checkOutput("c_we", ds_we_o, 1);
    checkOutput("c_waddr", ds_addr_o, 12);
    tick();
    checkOutput("c_gnt1", ld_gnt_o, 1);
    checkOutput("c_rd", ds_we_o, 0);
    checkOutput("c_raddr", ds_addr_o, 12);
    checkOutput("c_en", ds_en_o, 1);

    // reset in the middle of draining three entries
    ld_index_i = 8'd9;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(40 + i), 1'b0, 64'h77, 8'h01);
      tick();
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 64'd0, 8'd0);
    ld_req_i = 1'b0;
    #1;
    checkOutput("r_drain", ds_addr_o, 40);
    rst_i = 1'b1;
    #1;
    checkOutput("r_en", ds_en_o, 0);
    checkOutput("r_empty", empty_o, 1);
    checkOutput("r_ready", st_ready_o, 1);
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("r_quiet", ds_en_o, 0);
    end

    // flush drains two pending entries and blocks new stores
    ld_req_i = 1'b1;
    applyStimulus(1'b1, 8'd50, 1'b0, 64'h1, 8'h01);
    tick();
    applyStimulus(1'b1, 8'd51, 1'b0, 64'h2, 8'h01);
    tick();
    ld_req_i = 1'b0;
    flush_i = 1'b1;
    applyStimulus(1'b1, 8'd52, 1'b0, 64'h3, 8'h01);
    #1;
    checkOutput("fl_ready0", st_ready_o, 0);
    checkOutput("fl_addr0", ds_addr_o, 50);
    checkOutput("fl_we0", ds_we_o, 1);
    tick();
    checkOutput("fl_ready1", st_ready_o, 0);
    checkOutput("fl_addr1", ds_addr_o, 51);
    checkOutput("fl_we1", ds_we_o, 1);
    tick();
    checkOutput("fl_empty", empty_o, 1);
    checkOutput("fl_idle", ds_en_o, 0);
    checkOutput("fl_ready2", st_ready_o, 0);
    flush_i = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0, 64'd0, 8'd0);
    #1;
    checkOutput("fl_release", st_ready_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
